hilo_muldiv_unit: RTL
=====================

// Module: hilo_muldiv_unit
// PURPOSE
//   Iterative multiply/divide engine that owns the HI/LO register pair, replacing separate HI/LO
//   registers and single-cycle HI/LO ALU paths. Sits in EX beside ALU32Bit; accepts an op from
//   ID/EX, runs multi-cycle, writes HI/LO, and raises stall_o to freeze IF/ID/EX loads (Ld) on conflicts.
// PARAMETERS
//   WIDTH   32  operand width; HI, LO, hi_o, lo_o, wdata_i are WIDTH bits
//   CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   Clk      in   1      clock; all state changes on rising edge
//   Rst      in   1      synchronous, active-low reset
//   start_i  in   1      op request from EX stage
//   op_i     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
//   a_i      in   WIDTH  rs operand (dividend / multiplicand)
//   b_i      in   WIDTH  rt operand (divisor / multiplier)
//   wdata_i  in   WIDTH  data for MTHI/MTLO
//   rd_req_i in   1      MFHI/MFLO in ID this cycle
//   flush_i  in   1      abort in-flight op
//   hi_o     out  WIDTH  HI register
//   lo_o     out  WIDTH  LO register
//   busy_o   out  1      engine in RUN or FIX
//   done_o   out  1      one-cycle pulse: HI/LO just updated by a multi-cycle op
//   stall_o  out  1      combinational: busy_o & (rd_req_i | start_i)
// BEHAVIOUR
//   - Reset (Rst=0 at edge): state IDLE, HI=LO=0, busy_o=0, done_o=0, counter=0; overrides everything.
//   - FSM IDLE -> RUN -> FIX -> IDLE. start_i sampled only in IDLE; start_i while busy is ignored
//     (stall_o holds the requester until accepted).
//   - MTHI/MTLO: in IDLE, write wdata_i to HI/LO on the sampling edge; no busy, no done_o.
//   - Multi-cycle op: edge 0 samples start, latches |a|,|b| (signed ops) or raw operands, result
//     signs, op; enters RUN. Edges 1..WIDTH each perform one radix-2 step (shift-add multiply,
//     restoring divide). Edge WIDTH+1 (FIX): sign correction, HI/LO write, done_o=1, state IDLE.
//     Result visible WIDTH+1 edges after acceptance; done_o clears on the following edge.
//   - Multiply: 2*WIDTH product; HI = upper half, LO = lower half. Signed product negated if signs differ.
//   - Divide: LO = quotient, HI = remainder. Signed: quotient negated if signs differ; remainder takes
//     dividend sign. MIN/-1 -> LO=MIN, HI=0 (magnitude wrap, no trap).
//   - Divide by zero (b_i==0): HI = a_i, LO = all ones, same latency, no exception.
//   - flush_i in RUN/FIX: next edge -> IDLE, HI/LO unchanged, no done_o. flush_i in IDLE with start_i:
//     start dropped (MTHI/MTLO also dropped). flush_i has priority over FIX write on same edge.
//   - New start_i is accepted in the cycle done_o is high (back-to-back, no bubble).
//   - hi_o/lo_o always reflect committed HI/LO; intermediate values never visible.
// CONFIGURATION
//   HILO_ACCUM_EN defined: ops 110/111 are MADD/MSUB: signed product added to / subtracted from
//     {HI,LO} at FIX, 2*WIDTH-bit wraparound, same latency as MULT.
//   HILO_ACCUM_EN undefined: ops 110/111 are no-ops: not accepted as work, no busy, HI/LO untouched,
//     no done_o; accumulate datapath not synthesised.
// TESTING (WIDTH=32)
//   MULT a=0xFFFFFFFF b=5 -> after 33 edges HI=0xFFFFFFFF LO=0xFFFFFFFB, done_o one cycle; MULTU same
//     -> HI=0x00000004 LO=0xFFFFFFFB.
//   DIV a=0xFFFFFFF9(-7) b=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU a=100 b=0 -> HI=100 LO=0xFFFFFFFF.
//   DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000 HI=0; MTHI 0x1234 in IDLE -> hi_o=0x1234 next edge.
//   Start MULT, assert rd_req_i at cycle 5 -> stall_o=1 until done; flush_i at cycle 10 -> busy_o=0
//     next edge, HI/LO keep prior values, done_o never pulses.
//   Rst=0 mid-RUN -> next edge HI=LO=0, busy_o=0; start_i held during busy -> accepted on done_o cycle.
//   HILO_ACCUM_EN: HI:LO=0:10, MADD 3*4 -> LO=22 HI=0; MSUB 0xFFFFFFFF*2 -> LO=24. Undefined: HI/LO unchanged.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative HI/LO multiply/divide engine (shift-add multiply, restoring divide).
// Define HILO_ACCUM_EN to turn ops 110/111 into MADD/MSUB; otherwise they are ignored.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_req_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, mq, opnd, abs_a, abs_b, rdiff;
  logic [WIDTH:0] msum, r2;
  logic [2*WIDTH-1:0] prod, sprod;
  logic div_r, neg_q, neg_r, is_div, is_sgn, multi, dz, sa, sb, ge;
`ifdef HILO_ACCUM_EN
  logic accum_r, sub_r;
  assign multi = ~op_i[2] | op_i[1];
`else
  assign multi = ~op_i[2];
`endif
  assign is_sgn = op_i[2] | ~op_i[0];
  assign is_div = ~op_i[2] & op_i[1];
  assign dz = is_div & ~|b_i;
  // divide by zero runs unsigned so the restoring loop leaves a_i as remainder and all-ones quotient
  assign sa = is_sgn & a_i[WIDTH-1] & ~dz;
  assign sb = is_sgn & b_i[WIDTH-1];
  assign abs_a = sa ? -a_i : a_i;
  assign abs_b = sb ? -b_i : b_i;
  assign msum = {1'b0, acc} + {1'b0, opnd & {WIDTH{mq[0]}}};
  assign r2 = {acc, mq[WIDTH-1]};
  assign ge = r2 >= {1'b0, opnd};
  assign rdiff = r2[WIDTH-1:0] - opnd;
  assign prod = {acc, mq};
  assign sprod = neg_q ? -prod : prod;
  assign busy_o = state != IDLE;
  assign stall_o = busy_o & (rd_req_i | start_i);
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      cnt <= '0;
      hi_o <= '0;
      lo_o <= '0;
      done_o <= 1'b0;
      acc <= '0;
      mq <= '0;
      opnd <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`ifdef HILO_ACCUM_EN
      accum_r <= 1'b0;
      sub_r <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      if (flush_i) state <= IDLE;
      else if (state == IDLE) begin
        if (start_i && multi) begin
          state <= RUN;
          cnt <= '0;
          acc <= '0;
          mq <= is_div ? abs_a : abs_b;
          opnd <= is_div ? abs_b : abs_a;
          div_r <= is_div;
          neg_q <= sa ^ sb;
          neg_r <= sa;
`ifdef HILO_ACCUM_EN
          accum_r <= op_i[2];
          sub_r <= op_i[0];
`endif
        end else if (start_i && op_i == 3'b100) hi_o <= wdata_i;
        else if (start_i && op_i == 3'b101) lo_o <= wdata_i;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        if (div_r) begin
          acc <= ge ? rdiff : r2[WIDTH-1:0];
          mq <= {mq[WIDTH-2:0], ge};
        end else {acc, mq} <= {msum, mq[WIDTH-1:1]};
      end else begin
        state <= IDLE;
        done_o <= 1'b1;
        if (div_r) begin
          lo_o <= neg_q ? -mq : mq;
          hi_o <= neg_r ? -acc : acc;
        end
`ifdef HILO_ACCUM_EN
        else if (accum_r) {hi_o, lo_o} <= sub_r ? {hi_o, lo_o} - sprod : {hi_o, lo_o} + sprod;
`endif
        else {hi_o, lo_o} <= sprod;
      end
    end
  end
endmodule
